// File: rtl/four_bit_seq_multiplier.sv
// Sequential shift-add 4x4 unsigned multiplier driving a single four_bit_rca each CALC cycle.
// Optional macro MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.

module four_bit_rca (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  logic [4:0] c;
  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];
endmodule

module four_bit_seq_multiplier #(
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       BUSY,
  output logic       DONE
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] mcand_q, mcand_d;
  logic [3:0] q_q, q_d;
  logic [3:0] phi_q, phi_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;

  logic [3:0] add_b, sum;
  logic       cout;
  logic [3:0] phi_nx, q_nx;
  logic [2:0] cnt_nx;
  logic       exit_now;
  logic [7:0] exit_p;

  assign add_b = q_q[0] ? mcand_q : 4'h0;

  four_bit_rca u_rca (
    .A    (phi_q),
    .B    (add_b),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // {Cout,S} concatenated with Q, shifted right one place
  assign phi_nx = {cout, sum[3:1]};
  assign q_nx   = {sum[0], q_q[3:1]};
  assign cnt_nx = cnt_q + 3'd1;

`ifdef MULT_EARLY_EXIT_EN
  logic [3:0] rem_mask;
  logic       early;
  assign rem_mask = 4'hF >> cnt_q;
  assign early    = ((q_q & rem_mask) == 4'h0);
  assign exit_now = early || (cnt_nx == 3'd4);
  // Unprocessed bits are zero: align the partial product without further adds
  assign exit_p   = early ? ({phi_q, q_q} >> (3'd4 - cnt_q)) : {phi_nx, q_nx};
`else
  assign exit_now = (cnt_nx == 3'd4);
  assign exit_p   = {phi_nx, q_nx};
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      mcand_q <= 4'h0;
      q_q     <= 4'h0;
      phi_q   <= 4'h0;
      cnt_q   <= 3'd0;
      p_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      q_q     <= q_d;
      phi_q   <= phi_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    q_d     = q_q;
    phi_d   = phi_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          mcand_d = A;
          q_d     = B;
          phi_d   = 4'h0;
          cnt_d   = 3'd0;
          state_d = S_CALC;
        end else if (state_q == S_DONE && DONE_PULSE) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        phi_d = phi_nx;
        q_d   = q_nx;
        cnt_d = cnt_nx;
        if (exit_now) begin
          p_d     = exit_p;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign P    = p_q;
  assign BUSY = (state_q == S_CALC);
  assign DONE = (state_q == S_DONE);
endmodule

// File: tb/tb_four_bit_seq_multiplier.sv
// Randomized and directed bench for four_bit_seq_multiplier; pulse-mode and held-DONE instances.
module tb_four_bit_seq_multiplier;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, start0 = 1'b0;
  logic [3:0] a = 4'h0, b = 4'h0;
  logic [7:0] p1, p0;
  logic       busy1, busy0, done1, done0;

  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;                 // 0: pulse-mode DUT, 1: held-DONE DUT
  logic [7:0] last_p [2];
  logic [7:0] p_m;
  logic       busy_m, done_m;

  always #5 clk = ~clk;

  four_bit_seq_multiplier #(.DONE_PULSE(1'b1)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start1), .A(a), .B(b),
    .P(p1), .BUSY(busy1), .DONE(done1)
  );

  four_bit_seq_multiplier #(.DONE_PULSE(1'b0)) dut_hold (
    .CLK(clk), .RST_N(rst_n), .START(start0), .A(a), .B(b),
    .P(p0), .BUSY(busy0), .DONE(done0)
  );

  always_comb begin
    p_m    = sel ? p0 : p1;
    busy_m = sel ? busy0 : busy1;
    done_m = sel ? done0 : done1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] bb);
`ifdef MULT_EARLY_EXIT_EN
    int msb = -1;
    for (int i = 0; i < 4; i++) if (bb[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + 2 < 4) ? msb + 2 : 4;
`else
    return 4;
`endif
  endfunction

  // Called at a negedge with the selected DUT in IDLE or DONE; returns at the negedge DONE is seen.
  task automatic run_op(input bit s, input logic [3:0] aa, input logic [3:0] bb, input bit glitch);
    int cyc;
    sel = s;
    a = aa;
    b = bb;
    if (s) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    chk("busy_after_accept", busy_m, 1);
    chk("done_after_accept", done_m, 0);
    chk("p_held_in_calc", p_m, last_p[s]);
    if (glitch && exp_lat(bb) > 1) begin
      a = 4'h2;
      b = 4'h2;
      if (s) start0 = 1'b1; else start1 = 1'b1;
    end
    cyc = 0;
    while (!done_m && cyc < 12) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      cyc++;
      if (!done_m && cyc < 12) chk("busy_during_calc", busy_m, 1);
    end
    chk("latency", cyc, exp_lat(bb));
    chk("product", p_m, aa * bb);
    chk("busy_low_at_done", busy_m, 0);
    last_p[s] = 8'(aa * bb);
  endtask

  initial begin
    logic [3:0] ra, rb;
    last_p[0] = 8'h00;
    last_p[1] = 8'h00;

    // Reset held three cycles, then idle
    repeat (3) @(negedge clk);
    chk("rst_p", p1, 8'h00);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_p_hold", p0, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_p", p1, 8'h00);
    chk("idle_busy", busy1, 0);
    chk("idle_done", done1, 0);

    // 15x15 corner, DONE is a single-cycle pulse
    run_op(0, 4'hF, 4'hF, 0);
    @(negedge clk);
    chk("pulse_done_drop", done1, 0);
    chk("pulse_idle_busy", busy1, 0);
    chk("p_held_idle", p1, 8'hE1);

    run_op(0, 4'h6, 4'h0, 0);
    run_op(0, 4'h3, 4'h1, 0);
    // Second START mid-CALC must be ignored
    run_op(0, 4'h5, 4'h3, 1);

    // Reset during the second CALC cycle discards the operation
    @(negedge clk);
    sel = 0; a = 4'h9; b = 4'h7; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("busy_before_rst", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_p", p1, 8'h00);
    chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_p[0] = 8'h00;
    last_p[1] = 8'h00;
    repeat (6) begin
      @(negedge clk);
      chk("no_done_after_rst", done1, 0);
    end
    run_op(0, 4'h9, 4'h7, 0);

    // Held DONE mode
    @(negedge clk);
    run_op(1, 4'h7, 4'h8, 0);
    repeat (10) begin
      @(negedge clk);
      chk("held_done", done0, 1);
      chk("held_p", p0, 8'h38);
    end
    run_op(1, 4'h2, 4'h3, 0);

    // Exhaustive back-to-back on the pulse-mode DUT, STARTing on DONE
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      ra = 4'(i >> 4);
      rb = 4'(i);
      run_op(0, ra, rb, 0);
    end

    // Random operations on both DUTs with random gaps
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
